// File: rtl/signmag_pkg.sv
// Shared constants and the pipeline-depth helper for the signmag_split converter.
package signmag_pkg;

    localparam int DEFAULT_WIDTH     = 32;
    localparam int DEFAULT_SEG_WIDTH = 8;

    // Returns 0 for an illegal split so the top can reject it at elaboration.
    function automatic int num_seg(input int width, input int seg_width);
        if (width <= 0 || seg_width <= 0 || (width % seg_width) != 0) begin
            return 0;
        end
        return width / seg_width;
    endfunction

endpackage

// File: rtl/signmag_seg_stage.sv
// One pipeline register stage of signmag_split: negates segment SEG_IDX when the word is negative.
// The zero flag field only exists when SIGNMAG_SPLIT_ZERO_FLAG_EN is defined.
module signmag_seg_stage #(
    parameter int  WIDTH     = 32,
    parameter int  SEG_WIDTH = 8,
    parameter int  SEG_IDX   = 0,
    parameter type stage_t   = logic
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   hold,
    input  stage_t in_stage,
    output stage_t out_stage
);

    localparam int LO = SEG_IDX * SEG_WIDTH;

    logic [SEG_WIDTH-1:0] seg_in;
    logic [SEG_WIDTH-1:0] seg_new;
    logic                 carry_out;
    stage_t               stage_next;

    // Conditional invert-and-increment of one segment; the carry ripples into the next stage.
    always_comb begin
        seg_in               = in_stage.data[LO +: SEG_WIDTH];
        {carry_out, seg_new} = {1'b0, seg_in ^ {SEG_WIDTH{in_stage.sign}}}
                             + {{SEG_WIDTH{1'b0}}, in_stage.carry};
        stage_next                     = in_stage;
        stage_next.data[LO +: SEG_WIDTH] = seg_new;
        stage_next.carry               = carry_out;
`ifdef SIGNMAG_SPLIT_ZERO_FLAG_EN
        stage_next.zero                = in_stage.zero & (seg_new == '0);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_stage <= '0;
        end else if (!hold) begin
            out_stage <= stage_next;
        end
    end

endmodule

// File: rtl/signmag_split.sv
// Pipelined two's-complement to sign-magnitude converter, one carry-chain segment per stage.
// Define SIGNMAG_SPLIT_ZERO_FLAG_EN to add the out_zero (magnitude == 0) output.
module signmag_split
    import signmag_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int SEG_WIDTH = DEFAULT_SEG_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [WIDTH-1:0] out_mag,
    output logic             out_ovf
`ifdef SIGNMAG_SPLIT_ZERO_FLAG_EN
    ,
    output logic             out_zero
`endif
);

    localparam int NUM_SEG = num_seg(WIDTH, SEG_WIDTH);

    typedef struct packed {
        logic             valid;
        logic             sign;
        logic             carry;
`ifdef SIGNMAG_SPLIT_ZERO_FLAG_EN
        logic             zero;
`endif
        logic [WIDTH-1:0] data;
    } stage_t;

    stage_t head;
    stage_t tail;
    stage_t pipe [NUM_SEG];
    logic   stall;
    logic   unused_carry;

    if (NUM_SEG < 1) begin : g_bad_cfg
        $error("signmag_split: WIDTH must be a positive multiple of SEG_WIDTH");
    end

    // The sign doubles as the carry into segment 0, completing the +1 of the negation.
    always_comb begin
        head       = '0;
        head.valid = in_valid;
        head.sign  = in_data[WIDTH-1];
        head.carry = in_data[WIDTH-1];
`ifdef SIGNMAG_SPLIT_ZERO_FLAG_EN
        head.zero  = 1'b1;
`endif
        head.data  = in_data;
    end

    for (genvar k = 0; k < NUM_SEG; k++) begin : g_stage
        stage_t stage_in;
        if (k == 0) begin : g_head
            assign stage_in = head;
        end else begin : g_chain
            assign stage_in = pipe[k-1];
        end

        signmag_seg_stage #(
            .WIDTH     (WIDTH),
            .SEG_WIDTH (SEG_WIDTH),
            .SEG_IDX   (k),
            .stage_t   (stage_t)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .hold      (stall),
            .in_stage  (stage_in),
            .out_stage (pipe[k])
        );
    end

    assign tail         = pipe[NUM_SEG-1];
    assign unused_carry = tail.carry;

    // A single global stall freezes every stage, so bubbles are never squeezed out.
    assign stall     = tail.valid & ~out_ready;
    assign in_ready  = ~stall;

    assign out_valid = tail.valid;
    assign out_sign  = tail.sign;
    assign out_mag   = tail.data;
    assign out_ovf   = tail.sign & tail.data[WIDTH-1];
`ifdef SIGNMAG_SPLIT_ZERO_FLAG_EN
    assign out_zero  = tail.zero;
`endif

endmodule

// File: tb/tb_signmag_split.sv
// Directed-vector bench for signmag_split: a 4-stage instance plus a single-stage instance.
// Exercises out_zero as well when SIGNMAG_SPLIT_ZERO_FLAG_EN is defined.
module tb_signmag_split;

    logic        clk;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, out_sign, out_ovf;
    logic [31:0] in_data, out_mag;
    logic        in_valid1, in_ready1, out_valid1, out_sign1, out_ovf1;
    logic [31:0] in_data1, out_mag1;
`ifdef SIGNMAG_SPLIT_ZERO_FLAG_EN
    logic        out_zero, out_zero1;
`endif

    int vectors     = 0;
    int miscompares = 0;

    signmag_split #(.WIDTH(32), .SEG_WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_mag   (out_mag),
        .out_ovf   (out_ovf)
`ifdef SIGNMAG_SPLIT_ZERO_FLAG_EN
        ,
        .out_zero  (out_zero)
`endif
    );

    signmag_split #(.WIDTH(32), .SEG_WIDTH(32)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in_data   (in_data1),
        .out_valid (out_valid1),
        .out_ready (1'b1),
        .out_sign  (out_sign1),
        .out_mag   (out_mag1),
        .out_ovf   (out_ovf1)
`ifdef SIGNMAG_SPLIT_ZERO_FLAG_EN
        ,
        .out_zero  (out_zero1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_mag(input logic [31:0] x);
        return x[31] ? (32'd0 - x) : x;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid got %b want 0", out_valid); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
        vectors++; if (out_sign !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_sign got %b want 0", out_sign); end
        vectors++; if (out_mag !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_mag got %h want 0", out_mag); end
        vectors++; if (out_ovf !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ovf got %b want 0", out_ovf); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [31:0] vin [3] = '{32'd5, 32'hFFFF_FFFB, 32'd0};
        logic        es  [3] = '{1'b0, 1'b1, 1'b0};
        logic [31:0] em  [3] = '{32'd5, 32'd5, 32'd0};
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = vin[i];
            tick();
        end
        in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_latency got %b want 0", out_valid); end
        tick();
        for (int i = 0; i < 3; i++) begin
            vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_valid[%0d] got %b want 1", i, out_valid); end
            vectors++; if (out_sign !== es[i]) begin miscompares++; $display("[TB] FAIL basic_sign[%0d] got %b want %b", i, out_sign, es[i]); end
            vectors++; if (out_mag !== em[i]) begin miscompares++; $display("[TB] FAIL basic_mag[%0d] got %h want %h", i, out_mag, em[i]); end
            vectors++; if (out_ovf !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_ovf[%0d] got %b want 0", i, out_ovf); end
            tick();
        end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_drain got %b want 0", out_valid); end
    endtask

    task automatic test_boundary();
        logic [31:0] vin [6] = '{32'h8000_0000, 32'h8000_0001, 32'hFFFF_FF00,
                                 32'hFFFF_FFFF, 32'hFF00_0000, 32'h7FFF_FFFF};
        logic [31:0] em  [6] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0100,
                                 32'h0000_0001, 32'h0100_0000, 32'h7FFF_FFFF};
        logic        es  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic        eo  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 6 + 4; i++) begin
            in_valid = (i < 6);
            in_data  = (i < 6) ? vin[i] : 32'd0;
            tick();
            if (i >= 3 && i < 9) begin
                vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL bound_valid[%0d] got %b want 1", i-3, out_valid); end
                vectors++; if (out_sign !== es[i-3]) begin miscompares++; $display("[TB] FAIL bound_sign[%0d] got %b want %b", i-3, out_sign, es[i-3]); end
                vectors++; if (out_mag !== em[i-3]) begin miscompares++; $display("[TB] FAIL bound_mag[%0d] got %h want %h", i-3, out_mag, em[i-3]); end
                vectors++; if (out_ovf !== eo[i-3]) begin miscompares++; $display("[TB] FAIL bound_ovf[%0d] got %b want %b", i-3, out_ovf, eo[i-3]); end
            end
        end
        in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL bound_drain got %b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_q [$];
        logic [31:0] stim [10];
        logic [31:0] x;
        int sent  = 0;
        int got   = 0;
        int cycle = 0;
        for (int i = 0; i < 10; i++) stim[i] = $urandom;
        stim[2] = 32'h8000_0000;
        while (got < 10 && cycle < 200) begin
            out_ready = !(cycle >= 6 && cycle < 11);
            in_valid  = (sent < 10);
            if (sent < 10) in_data = stim[sent];
            #1;
            if (!out_ready && out_valid) begin
                vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_in_ready cycle %0d got %b want 0", cycle, in_ready); end
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    vectors++; miscompares++; $display("[TB] FAIL bp_extra cycle %0d got mag %h want no output", cycle, out_mag);
                end else begin
                    x = exp_q[0];
                    vectors++; if (out_sign !== x[31]) begin miscompares++; $display("[TB] FAIL bp_sign[%0d] got %b want %b", got, out_sign, x[31]); end
                    vectors++; if (out_mag !== ref_mag(x)) begin miscompares++; $display("[TB] FAIL bp_mag[%0d] got %h want %h", got, out_mag, ref_mag(x)); end
                    vectors++; if (out_ovf !== (x == 32'h8000_0000)) begin miscompares++; $display("[TB] FAIL bp_ovf[%0d] got %b want %b", got, out_ovf, (x == 32'h8000_0000)); end
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        got++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(stim[sent]);
                sent++;
            end
            @(posedge clk);
            #1;
            cycle++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        vectors++; if (got != 10) begin miscompares++; $display("[TB] FAIL bp_count got %0d want 10", got); end
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 32'h0000_0100 + i;
            tick();
        end
        in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_pre_valid got %b want 1", out_valid); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_async_valid got %b want 0", out_valid); end
        vectors++; if (out_mag !== 32'd0) begin miscompares++; $display("[TB] FAIL mid_async_mag got %h want 0", out_mag); end
        #3 rst_n = 1'b1;
        in_valid = 1'b1; in_data = 32'hFFFF_FFF6;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_flushed[%0d] got %b want 0", i, out_valid); end
            tick();
        end
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_new_valid got %b want 1", out_valid); end
        vectors++; if (out_mag !== 32'd10) begin miscompares++; $display("[TB] FAIL mid_new_mag got %h want 0000000a", out_mag); end
        vectors++; if (out_sign !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_new_sign got %b want 1", out_sign); end
        tick();
    endtask

    task automatic test_single_stage();
        in_valid1 = 1'b1; in_data1 = 32'hFFFF_FFF6;
        tick();
        in_data1 = 32'd7;
        vectors++; if (out_valid1 !== 1'b1) begin miscompares++; $display("[TB] FAIL seg1_valid got %b want 1", out_valid1); end
        vectors++; if (out_sign1 !== 1'b1) begin miscompares++; $display("[TB] FAIL seg1_sign got %b want 1", out_sign1); end
        vectors++; if (out_mag1 !== 32'd10) begin miscompares++; $display("[TB] FAIL seg1_mag got %h want 0000000a", out_mag1); end
        tick();
        in_valid1 = 1'b0;
        vectors++; if (out_mag1 !== 32'd7 || out_sign1 !== 1'b0) begin miscompares++; $display("[TB] FAIL seg1_pos got %b/%h want 0/00000007", out_sign1, out_mag1); end
        tick();
        vectors++; if (out_valid1 !== 1'b0) begin miscompares++; $display("[TB] FAIL seg1_drain got %b want 0", out_valid1); end
    endtask

`ifdef SIGNMAG_SPLIT_ZERO_FLAG_EN
    task automatic test_zero_flag();
        logic [31:0] vin [3] = '{32'd0, 32'd1, 32'hFFFF_FFFF};
        logic        ez  [3] = '{1'b1, 1'b0, 1'b0};
        vectors++; if (out_zero !== 1'b0) begin miscompares++; $display("[TB] FAIL zero_idle got %b want 0", out_zero); end
        for (int i = 0; i < 3 + 4; i++) begin
            in_valid = (i < 3);
            in_data  = (i < 3) ? vin[i] : 32'd0;
            tick();
            if (i >= 3 && i < 6) begin
                vectors++; if (out_zero !== ez[i-3]) begin miscompares++; $display("[TB] FAIL zero_flag[%0d] got %b want %b", i-3, out_zero, ez[i-3]); end
            end
        end
        in_valid = 1'b0;
    endtask
`endif

    initial begin
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        in_valid1 = 1'b0;
        in_data1  = '0;
        test_reset();
        test_basic();
        test_boundary();
        test_backpressure();
        test_reset_midstream();
        test_single_stage();
`ifdef SIGNMAG_SPLIT_ZERO_FLAG_EN
        test_zero_flag();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired got timeout want completion");
        $fatal(1, "[TB] watchdog");
    end

endmodule
